// File: rtl/ebrick_mem_arbiter.sv
// ---------------------------------------------------------------------------
// ebrick_mem_arbiter
//
// Shares one UMI memory device port between two requesters: u0 (core) and
// u1 (host loader).
//
// Request path:
//   - Round-robin arbitration feeds a one-entry register stage that drives
//     m_req_*. A request accepted on edge N is visible on m_req_* right after
//     that edge.
//   - The stage loads when it is empty, or when it unloads in the same cycle.
// Response path:
//   - A small tag FIFO records which port issued each response-expecting
//     request (READ 0x01, WRITE 0x03, ATOMIC 0x09 in cmd[4:0]).
//   - m_resp_* is routed combinationally to the port at the FIFO head.
//   - The tag is popped on a response transfer with EOM (cmd[22]) set.
//
// Handshake rule on every channel: a transfer happens on a rising clk edge
// where valid and ready are both 1. A source holds valid and its payload
// stable until that transfer.
//
// Parameters:
//   DW     UMI data width
//   AW     UMI address width
//   CW     UMI command width (must be >= 23 so the EOM bit exists)
//   DEPTH  tag FIFO entries (power of 2, >= 2)
//
// Ports:
//   clk, nreset                      clock, synchronous active-low reset
//   u0_req_*  / u0_req_ready         requester 0 request channel
//   u0_resp_* / u0_resp_ready        requester 0 response channel
//   u1_req_*  / u1_req_ready         requester 1 request channel
//   u1_resp_* / u1_resp_ready        requester 1 response channel
//   m_req_*   / m_req_ready          request to memory agent
//   m_resp_*  / m_resp_ready         response from memory agent
//   gnt0_count, gnt1_count           request transfer counters, only present
//                                    when EBRICK_MEM_ARB_STATS_EN is defined
//
// Optional feature macro: EBRICK_MEM_ARB_STATS_EN
// ---------------------------------------------------------------------------
module ebrick_mem_arbiter #(
  parameter int DW    = 32,
  parameter int AW    = 64,
  parameter int CW    = 32,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          nreset,
  // requester 0 (core)
  input  logic          u0_req_valid,
  input  logic [CW-1:0] u0_req_cmd,
  input  logic [AW-1:0] u0_req_dstaddr,
  input  logic [AW-1:0] u0_req_srcaddr,
  input  logic [DW-1:0] u0_req_data,
  output logic          u0_req_ready,
  output logic          u0_resp_valid,
  output logic [CW-1:0] u0_resp_cmd,
  output logic [AW-1:0] u0_resp_dstaddr,
  output logic [AW-1:0] u0_resp_srcaddr,
  output logic [DW-1:0] u0_resp_data,
  input  logic          u0_resp_ready,
  // requester 1 (host loader)
  input  logic          u1_req_valid,
  input  logic [CW-1:0] u1_req_cmd,
  input  logic [AW-1:0] u1_req_dstaddr,
  input  logic [AW-1:0] u1_req_srcaddr,
  input  logic [DW-1:0] u1_req_data,
  output logic          u1_req_ready,
  output logic          u1_resp_valid,
  output logic [CW-1:0] u1_resp_cmd,
  output logic [AW-1:0] u1_resp_dstaddr,
  output logic [AW-1:0] u1_resp_srcaddr,
  output logic [DW-1:0] u1_resp_data,
  input  logic          u1_resp_ready,
  // memory agent
  output logic          m_req_valid,
  output logic [CW-1:0] m_req_cmd,
  output logic [AW-1:0] m_req_dstaddr,
  output logic [AW-1:0] m_req_srcaddr,
  output logic [DW-1:0] m_req_data,
  input  logic          m_req_ready,
  input  logic          m_resp_valid,
  input  logic [CW-1:0] m_resp_cmd,
  input  logic [AW-1:0] m_resp_dstaddr,
  input  logic [AW-1:0] m_resp_srcaddr,
  input  logic [DW-1:0] m_resp_data,
  output logic          m_resp_ready
`ifdef EBRICK_MEM_ARB_STATS_EN
  ,
  output logic [31:0]   gnt0_count,
  output logic [31:0]   gnt1_count
`endif
);

  localparam int PW   = $clog2(DEPTH);
  localparam int CNTW = PW + 1;
  localparam int EOM_BIT = 22;

  // Opcodes that are answered by the memory agent and therefore need a tag.
  function automatic logic expects_resp(input logic [CW-1:0] cmd);
    logic r;
    r = 1'b0;
    case (cmd[4:0])
      5'h01, 5'h03, 5'h09: r = 1'b1;
      default:             r = 1'b0;
    endcase
    return r;
  endfunction

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic            stg_valid;
  logic [CW-1:0]   stg_cmd;
  logic [AW-1:0]   stg_dstaddr;
  logic [AW-1:0]   stg_srcaddr;
  logic [DW-1:0]   stg_data;

  // Round-robin state. Set means port 0 won the most recent grant, so port 1
  // has priority on the next contended cycle. Reset value 1 gives u1 the
  // first contended grant.
  logic            last_gnt;

  logic            tag_mem [DEPTH];
  logic [PW-1:0]   tag_wr_ptr;
  logic [PW-1:0]   tag_rd_ptr;
  logic [CNTW-1:0] tag_count;

  // -------------------------------------------------------------------------
  // Arbitration and request acceptance
  // -------------------------------------------------------------------------
  logic            tag_full;
  logic            tag_empty;
  logic            elig0;
  logic            elig1;
  logic            gnt0;
  logic            gnt1;
  logic            stg_can_load;
  logic            xfer0;
  logic            xfer1;
  logic            req_xfer;
  logic [CW-1:0]   sel_cmd;
  logic [AW-1:0]   sel_dstaddr;
  logic [AW-1:0]   sel_srcaddr;
  logic [DW-1:0]   sel_data;
  logic            tag_push;
  logic            tag_pop;
  logic            tag_head;

  assign tag_full  = (tag_count == CNTW'(DEPTH));
  assign tag_empty = (tag_count == '0);

  // A port is only considered if it can actually be accepted. A
  // response-expecting request blocked by a full tag FIFO must not win
  // arbitration, otherwise it would also block posted traffic from the
  // other port.
  assign elig0 = u0_req_valid & (~expects_resp(u0_req_cmd) | ~tag_full);
  assign elig1 = u1_req_valid & (~expects_resp(u1_req_cmd) | ~tag_full);

  assign gnt1 = elig1 & (~elig0 | last_gnt);
  assign gnt0 = elig0 & ~gnt1;

  assign stg_can_load = ~stg_valid | m_req_ready;

  // Ready is forced low while reset is asserted so no transfer is reported
  // on an edge that the block ignores.
  assign u0_req_ready = nreset & stg_can_load & gnt0;
  assign u1_req_ready = nreset & stg_can_load & gnt1;

  assign xfer0    = u0_req_valid & u0_req_ready;
  assign xfer1    = u1_req_valid & u1_req_ready;
  assign req_xfer = xfer0 | xfer1;

  always_comb begin
    sel_cmd     = u0_req_cmd;
    sel_dstaddr = u0_req_dstaddr;
    sel_srcaddr = u0_req_srcaddr;
    sel_data    = u0_req_data;
    if (xfer1) begin
      sel_cmd     = u1_req_cmd;
      sel_dstaddr = u1_req_dstaddr;
      sel_srcaddr = u1_req_srcaddr;
      sel_data    = u1_req_data;
    end
  end

  assign tag_push = req_xfer & expects_resp(sel_cmd);

  // -------------------------------------------------------------------------
  // Request stage
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!nreset) begin
      stg_valid   <= 1'b0;
      stg_cmd     <= '0;
      stg_dstaddr <= '0;
      stg_srcaddr <= '0;
      stg_data    <= '0;
    end else if (req_xfer) begin
      stg_valid   <= 1'b1;
      stg_cmd     <= sel_cmd;
      stg_dstaddr <= sel_dstaddr;
      stg_srcaddr <= sel_srcaddr;
      stg_data    <= sel_data;
    end else if (m_req_ready) begin
      stg_valid   <= 1'b0;
    end
  end

  assign m_req_valid   = stg_valid;
  assign m_req_cmd     = stg_cmd;
  assign m_req_dstaddr = stg_dstaddr;
  assign m_req_srcaddr = stg_srcaddr;
  assign m_req_data    = stg_data;

  always_ff @(posedge clk) begin
    if (!nreset) begin
      last_gnt <= 1'b1;
    end else if (req_xfer) begin
      last_gnt <= xfer0;
    end
  end

  // -------------------------------------------------------------------------
  // Tag FIFO: one bit per outstanding response-expecting request, holding
  // the issuing port index. Pointers wrap naturally because DEPTH is a power
  // of two. Reset only clears the pointers and count; stale entries are
  // never read because the FIFO is empty.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (tag_push) begin
      tag_mem[tag_wr_ptr] <= xfer1;
    end
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      tag_wr_ptr <= '0;
      tag_rd_ptr <= '0;
      tag_count  <= '0;
    end else begin
      if (tag_push) begin
        tag_wr_ptr <= tag_wr_ptr + 1'b1;
      end
      if (tag_pop) begin
        tag_rd_ptr <= tag_rd_ptr + 1'b1;
      end
      case ({tag_push, tag_pop})
        2'b10:   tag_count <= tag_count + 1'b1;
        2'b01:   tag_count <= tag_count - 1'b1;
        default: tag_count <= tag_count;
      endcase
    end
  end

  assign tag_head = tag_mem[tag_rd_ptr];

  // -------------------------------------------------------------------------
  // Response routing
  // -------------------------------------------------------------------------
  assign m_resp_ready = ~tag_empty & (tag_head ? u1_resp_ready : u0_resp_ready);

  // Multi-beat responses keep the tag until the beat carrying EOM.
  assign tag_pop = m_resp_valid & m_resp_ready & m_resp_cmd[EOM_BIT];

  assign u0_resp_valid = m_resp_valid & ~tag_empty & ~tag_head;
  assign u1_resp_valid = m_resp_valid & ~tag_empty &  tag_head;

  // Payload fans out to both ports; only the valid selects the receiver.
  assign u0_resp_cmd     = m_resp_cmd;
  assign u0_resp_dstaddr = m_resp_dstaddr;
  assign u0_resp_srcaddr = m_resp_srcaddr;
  assign u0_resp_data    = m_resp_data;
  assign u1_resp_cmd     = m_resp_cmd;
  assign u1_resp_dstaddr = m_resp_dstaddr;
  assign u1_resp_srcaddr = m_resp_srcaddr;
  assign u1_resp_data    = m_resp_data;

  // -------------------------------------------------------------------------
  // Optional grant statistics
  // -------------------------------------------------------------------------
`ifdef EBRICK_MEM_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (!nreset) begin
      gnt0_count <= '0;
      gnt1_count <= '0;
    end else begin
      if (xfer0) begin
        gnt0_count <= gnt0_count + 32'd1;
      end
      if (xfer1) begin
        gnt1_count <= gnt1_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_ebrick_mem_arbiter.sv
module tb_ebrick_mem_arbiter;

  localparam int DW = 32;
  localparam int AW = 64;
  localparam int CW = 32;
  localparam logic [31:0] EOM = 32'h0040_0000;

  logic          clk = 1'b0;
  logic          nreset;
  logic          u0_req_valid, u1_req_valid;
  logic [CW-1:0] u0_req_cmd, u1_req_cmd;
  logic [AW-1:0] u0_req_dstaddr, u1_req_dstaddr;
  logic [AW-1:0] u0_req_srcaddr, u1_req_srcaddr;
  logic [DW-1:0] u0_req_data, u1_req_data;
  logic          u0_req_ready, u1_req_ready;
  logic          u0_resp_valid, u1_resp_valid;
  logic [CW-1:0] u0_resp_cmd, u1_resp_cmd;
  logic [AW-1:0] u0_resp_dstaddr, u1_resp_dstaddr;
  logic [AW-1:0] u0_resp_srcaddr, u1_resp_srcaddr;
  logic [DW-1:0] u0_resp_data, u1_resp_data;
  logic          u0_resp_ready, u1_resp_ready;
  logic          m_req_valid;
  logic [CW-1:0] m_req_cmd;
  logic [AW-1:0] m_req_dstaddr;
  logic [AW-1:0] m_req_srcaddr;
  logic [DW-1:0] m_req_data;
  logic          m_req_ready;
  logic          m_resp_valid;
  logic [CW-1:0] m_resp_cmd;
  logic [AW-1:0] m_resp_dstaddr;
  logic [AW-1:0] m_resp_srcaddr;
  logic [DW-1:0] m_resp_data;
  logic          m_resp_ready;
`ifdef EBRICK_MEM_ARB_STATS_EN
  logic [31:0]   gnt0_count, gnt1_count;
`endif

  ebrick_mem_arbiter #(.DW(DW), .AW(AW), .CW(CW), .DEPTH(4)) dut (
    .clk            (clk),
    .nreset         (nreset),
    .u0_req_valid   (u0_req_valid),
    .u0_req_cmd     (u0_req_cmd),
    .u0_req_dstaddr (u0_req_dstaddr),
    .u0_req_srcaddr (u0_req_srcaddr),
    .u0_req_data    (u0_req_data),
    .u0_req_ready   (u0_req_ready),
    .u0_resp_valid  (u0_resp_valid),
    .u0_resp_cmd    (u0_resp_cmd),
    .u0_resp_dstaddr(u0_resp_dstaddr),
    .u0_resp_srcaddr(u0_resp_srcaddr),
    .u0_resp_data   (u0_resp_data),
    .u0_resp_ready  (u0_resp_ready),
    .u1_req_valid   (u1_req_valid),
    .u1_req_cmd     (u1_req_cmd),
    .u1_req_dstaddr (u1_req_dstaddr),
    .u1_req_srcaddr (u1_req_srcaddr),
    .u1_req_data    (u1_req_data),
    .u1_req_ready   (u1_req_ready),
    .u1_resp_valid  (u1_resp_valid),
    .u1_resp_cmd    (u1_resp_cmd),
    .u1_resp_dstaddr(u1_resp_dstaddr),
    .u1_resp_srcaddr(u1_resp_srcaddr),
    .u1_resp_data   (u1_resp_data),
    .u1_resp_ready  (u1_resp_ready),
    .m_req_valid    (m_req_valid),
    .m_req_cmd      (m_req_cmd),
    .m_req_dstaddr  (m_req_dstaddr),
    .m_req_srcaddr  (m_req_srcaddr),
    .m_req_data     (m_req_data),
    .m_req_ready    (m_req_ready),
    .m_resp_valid   (m_resp_valid),
    .m_resp_cmd     (m_resp_cmd),
    .m_resp_dstaddr (m_resp_dstaddr),
    .m_resp_srcaddr (m_resp_srcaddr),
    .m_resp_data    (m_resp_data),
    .m_resp_ready   (m_resp_ready)
`ifdef EBRICK_MEM_ARB_STATS_EN
    ,
    .gnt0_count     (gnt0_count),
    .gnt1_count     (gnt1_count)
`endif
  );

  // ---------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------
  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  initial begin
    #200000;
    $display("FAIL watchdog: actual timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled
  // on the falling edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  // ---------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------
  task automatic idle_inputs();
    u0_req_valid = 1'b0; u0_req_cmd = '0; u0_req_dstaddr = '0; u0_req_srcaddr = '0; u0_req_data = '0;
    u1_req_valid = 1'b0; u1_req_cmd = '0; u1_req_dstaddr = '0; u1_req_srcaddr = '0; u1_req_data = '0;
    u0_resp_ready = 1'b1;
    u1_resp_ready = 1'b1;
    m_req_ready   = 1'b1;
    m_resp_valid  = 1'b0; m_resp_cmd = '0; m_resp_dstaddr = '0; m_resp_srcaddr = '0; m_resp_data = '0;
  endtask

  task automatic do_reset();
    nreset = 1'b0;
    idle_inputs();
    cyc();
    cyc();
    nreset = 1'b1;
  endtask

  task automatic drive_req(input int port, input logic v, input logic [31:0] cmd,
                           input logic [63:0] dst, input logic [63:0] src);
    if (port == 0) begin
      u0_req_valid = v; u0_req_cmd = cmd; u0_req_dstaddr = dst; u0_req_srcaddr = src;
      u0_req_data = dst[31:0];
    end else begin
      u1_req_valid = v; u1_req_cmd = cmd; u1_req_dstaddr = dst; u1_req_srcaddr = src;
      u1_req_data = dst[31:0];
    end
  endtask

  task automatic drive_resp(input logic v, input logic [31:0] cmd, input logic [31:0] data);
    m_resp_valid = v;
    m_resp_cmd   = cmd;
    m_resp_data  = data;
    m_resp_dstaddr = 64'h0;
    m_resp_srcaddr = 64'h0;
  endtask

  // ---------------------------------------------------------------------
  // Vector table: opcode decode and response routing per port
  // ---------------------------------------------------------------------
  typedef struct {
    int          port;
    logic [31:0] cmd;
    logic        exp_resp;
  } vec_t;

  vec_t vecs[9];

  int acc0, acc1;
  logic have_dst, stable;
  logic [63:0] capt_dst;

  initial begin
    vecs[0] = '{0, 32'h0000_0001, 1'b1};  // READ
    vecs[1] = '{1, 32'h0000_0003, 1'b1};  // WRITE
    vecs[2] = '{0, 32'h0000_0009, 1'b1};  // ATOMIC
    vecs[3] = '{1, 32'h0000_0005, 1'b0};  // posted write
    vecs[4] = '{0, 32'h0000_0000, 1'b0};  // invalid opcode
    vecs[5] = '{1, 32'h0000_00E1, 1'b1};  // READ with upper cmd bits set
    vecs[6] = '{0, 32'h0000_0002, 1'b0};
    vecs[7] = '{1, 32'h0000_001F, 1'b0};
    vecs[8] = '{0, 32'h0000_0011, 1'b0};  // low nibble 1 but bit4 set

    // ---- reset state, with requests and a response pending ----
    nreset = 1'b0;
    idle_inputs();
    drive_req(0, 1'b1, 32'h1, 64'h10, 64'h0);
    drive_req(1, 1'b1, 32'h1, 64'h20, 64'h0);
    drive_resp(1'b1, EOM, 32'h1234);
    cyc();
    neg();
    chk("rst_m_req_valid", m_req_valid, 0);
    chk("rst_u0_req_ready", u0_req_ready, 0);
    chk("rst_u1_req_ready", u1_req_ready, 0);
    chk("rst_m_resp_ready", m_resp_ready, 0);
    chk("rst_u0_resp_valid", u0_resp_valid, 0);
    chk("rst_u1_resp_valid", u1_resp_valid, 0);
`ifdef EBRICK_MEM_ARB_STATS_EN
    chk("rst_gnt0_count", gnt0_count, 0);
    chk("rst_gnt1_count", gnt1_count, 0);
`endif
    do_reset();

    // ---- single read ----
    drive_req(0, 1'b1, 32'h1, 64'h100, 64'h55);
    neg();
    chk("sr_accept", u0_req_ready, 1);
    chk("sr_latency", m_req_valid, 0);
    cyc();
    drive_req(0, 1'b0, 32'h0, 64'h0, 64'h0);
    neg();
    chk("sr_m_req_valid", m_req_valid, 1);
    chk("sr_m_req_dst", m_req_dstaddr, 64'h100);
    chk("sr_m_req_src", m_req_srcaddr, 64'h55);
    cyc();
    drive_resp(1'b1, EOM | 32'h2, 32'hDEADBEEF);
    neg();
    chk("sr_u0_resp_valid", u0_resp_valid, 1);
    chk("sr_u0_resp_data", u0_resp_data, 32'hDEADBEEF);
    chk("sr_u1_resp_valid", u1_resp_valid, 0);
    chk("sr_m_resp_ready", m_resp_ready, 1);
    cyc();
    neg();
    chk("sr_after_pop_ready", m_resp_ready, 0);
    chk("sr_after_pop_valid", u0_resp_valid, 0);
    cyc();
    drive_resp(1'b0, 32'h0, 32'h0);

    // ---- table vectors ----
    for (int i = 0; i < 9; i++) begin
      drive_req(vecs[i].port, 1'b1, vecs[i].cmd, 64'h200 + 64'(i), 64'h0);
      neg();
      chk($sformatf("vec%0d_req_ready", i),
          (vecs[i].port == 0) ? u0_req_ready : u1_req_ready, 1);
      cyc();
      drive_req(vecs[i].port, 1'b0, 32'h0, 64'h0, 64'h0);
      neg();
      chk($sformatf("vec%0d_m_req_valid", i), m_req_valid, 1);
      chk($sformatf("vec%0d_m_req_cmd", i), m_req_cmd, vecs[i].cmd);
      cyc();
      drive_resp(1'b1, EOM, 32'hA000 + 32'(i));
      neg();
      chk($sformatf("vec%0d_m_resp_ready", i), m_resp_ready, vecs[i].exp_resp);
      chk($sformatf("vec%0d_own_resp_valid", i),
          (vecs[i].port == 0) ? u0_resp_valid : u1_resp_valid, vecs[i].exp_resp);
      chk($sformatf("vec%0d_other_resp_valid", i),
          (vecs[i].port == 0) ? u1_resp_valid : u0_resp_valid, 0);
      cyc();
      drive_resp(1'b0, 32'h0, 32'h0);
    end

    // ---- contention: grants alternate u1, u0, u1, u0 after reset ----
    do_reset();
    drive_req(0, 1'b1, 32'h5, 64'h300, 64'hA0);
    drive_req(1, 1'b1, 32'h5, 64'h301, 64'hA1);
    for (int i = 0; i < 4; i++) begin
      neg();
      chk($sformatf("ct_grant%0d", i), {u1_req_ready, u0_req_ready},
          (i % 2 == 0) ? 2'b10 : 2'b01);
      if (i > 0)
        chk($sformatf("ct_m_req_src%0d", i), m_req_srcaddr,
            (i % 2 == 1) ? 64'hA1 : 64'hA0);
      cyc();
    end
    idle_inputs();

    // ---- tag full: 4 reads stall the 5th, posted write still flows ----
    do_reset();
    drive_req(0, 1'b1, 32'h1, 64'h400, 64'h0);
    for (int i = 0; i < 4; i++) begin
      neg();
      chk($sformatf("tf_ready%0d", i), u0_req_ready, 1);
      cyc();
    end
    neg();
    chk("tf_fifth_stalled", u0_req_ready, 0);
    cyc();
    drive_req(1, 1'b1, 32'h5, 64'h480, 64'h0);
    neg();
    chk("tf_posted_ready", u1_req_ready, 1);
    chk("tf_u0_still_stalled", u0_req_ready, 0);
    cyc();
    drive_req(0, 1'b0, 32'h0, 64'h0, 64'h0);
    drive_req(1, 1'b0, 32'h0, 64'h0, 64'h0);
    neg();
    chk("tf_posted_out_valid", m_req_valid, 1);
    chk("tf_posted_out_cmd", m_req_cmd, 32'h5);
    cyc();
    drive_resp(1'b1, EOM, 32'hF00D);
    for (int i = 0; i < 4; i++) begin
      neg();
      chk($sformatf("tf_drain%0d", i), u0_resp_valid, 1);
      cyc();
    end
    neg();
    chk("tf_drained_ready", m_resp_ready, 0);
    cyc();
    drive_resp(1'b0, 32'h0, 32'h0);

    // ---- ordering, multi-beat response, push and pop in one cycle ----
    do_reset();
    drive_req(0, 1'b1, 32'h1, 64'h500, 64'h0);
    neg();
    chk("or_u0_accept", u0_req_ready, 1);
    cyc();
    drive_req(0, 1'b0, 32'h0, 64'h0, 64'h0);
    drive_req(1, 1'b1, 32'h1, 64'h510, 64'h0);
    neg();
    chk("or_u1_accept", u1_req_ready, 1);
    cyc();
    drive_req(1, 1'b0, 32'h0, 64'h0, 64'h0);
    drive_resp(1'b1, 32'h2, 32'h1111);      // EOM = 0: tag kept
    neg();
    chk("or_beat0_u0", u0_resp_valid, 1);
    chk("or_beat0_u1_quiet", u1_resp_valid, 0);
    cyc();
    drive_resp(1'b1, EOM | 32'h2, 32'h2222);
    drive_req(0, 1'b1, 32'h1, 64'h520, 64'h0);
    neg();
    chk("or_beat1_u0", u0_resp_valid, 1);
    chk("or_beat1_u1_quiet", u1_resp_valid, 0);
    chk("or_push_with_pop", u0_req_ready, 1);
    cyc();
    drive_req(0, 1'b0, 32'h0, 64'h0, 64'h0);
    drive_resp(1'b1, EOM | 32'h2, 32'h3333);
    neg();
    chk("or_second_u1", u1_resp_valid, 1);
    chk("or_second_u0_quiet", u0_resp_valid, 0);
    chk("or_second_data", u1_resp_data, 32'h3333);
    cyc();
    neg();
    chk("or_third_u0", u0_resp_valid, 1);
    cyc();
    neg();
    chk("or_empty_ready", m_resp_ready, 0);
    cyc();
    drive_resp(1'b0, 32'h0, 32'h0);

    // ---- backpressure ----
    do_reset();
    m_req_ready = 1'b0;
    drive_req(0, 1'b1, 32'h1, 64'hA0, 64'h0);
    drive_req(1, 1'b1, 32'h1, 64'hB0, 64'h0);
    acc0 = 0; acc1 = 0; have_dst = 1'b0; stable = 1'b1; capt_dst = '0;
    for (int i = 0; i < 10; i++) begin
      logic drop0, drop1;
      neg();
      drop0 = u0_req_valid & u0_req_ready;
      drop1 = u1_req_valid & u1_req_ready;
      if (drop0) acc0++;
      if (drop1) acc1++;
      if (m_req_valid) begin
        if (!have_dst) begin
          capt_dst = m_req_dstaddr;
          have_dst = 1'b1;
        end else if (m_req_dstaddr !== capt_dst) begin
          stable = 1'b0;
        end
      end
      cyc();
      if (drop0) drive_req(0, 1'b0, 32'h0, 64'h0, 64'h0);
      if (drop1) drive_req(1, 1'b0, 32'h0, 64'h0, 64'h0);
    end
    chk("bp_u1_accepts", acc1, 1);
    chk("bp_u0_accepts", acc0, 0);
    chk("bp_stage_dst", capt_dst, 64'hB0);
    chk("bp_stable", stable, 1);
    m_req_ready = 1'b1;
    neg();
    chk("bp_u0_after_release", u0_req_ready, 1);
    cyc();
    drive_req(0, 1'b0, 32'h0, 64'h0, 64'h0);
    neg();
    chk("bp_u0_dst_out", m_req_dstaddr, 64'hA0);
    cyc();
    u0_resp_ready = 1'b0;
    drive_resp(1'b1, EOM, 32'hBBBB);
    neg();
    chk("bp_u1_resp_valid", u1_resp_valid, 1);
    chk("bp_u1_resp_taken", m_resp_ready, 1);
    cyc();
    neg();
    chk("bp_hold_ready0", m_resp_ready, 0);
    chk("bp_u0_resp_valid", u0_resp_valid, 1);
    cyc();
    neg();
    chk("bp_hold_ready1", m_resp_ready, 0);
    cyc();
    u0_resp_ready = 1'b1;
    neg();
    chk("bp_release_ready", m_resp_ready, 1);
    cyc();
    drive_resp(1'b0, 32'h0, 32'h0);

    // ---- reset with two reads outstanding and one staged ----
    do_reset();
    drive_req(0, 1'b1, 32'h1, 64'h600, 64'h0);
    neg();
    chk("rm_u0_accept", u0_req_ready, 1);
    cyc();
    drive_req(0, 1'b0, 32'h0, 64'h0, 64'h0);
    drive_req(1, 1'b1, 32'h1, 64'h610, 64'h0);
    neg();
    chk("rm_u1_accept", u1_req_ready, 1);
    cyc();
    drive_req(1, 1'b0, 32'h0, 64'h0, 64'h0);
    m_req_ready = 1'b0;
    neg();
    chk("rm_staged", m_req_valid, 1);
`ifdef EBRICK_MEM_ARB_STATS_EN
    chk("rm_gnt0_before", gnt0_count, 1);
    chk("rm_gnt1_before", gnt1_count, 1);
`endif
    cyc();
    nreset = 1'b0;
    cyc();
    cyc();
    nreset = 1'b1;
    drive_resp(1'b1, EOM, 32'h7777);
    neg();
    chk("rm_m_req_valid", m_req_valid, 0);
    chk("rm_m_resp_ready", m_resp_ready, 0);
    chk("rm_u0_resp_valid", u0_resp_valid, 0);
    chk("rm_u1_resp_valid", u1_resp_valid, 0);
`ifdef EBRICK_MEM_ARB_STATS_EN
    chk("rm_gnt0_after", gnt0_count, 0);
    chk("rm_gnt1_after", gnt1_count, 0);
`endif
    cyc();
    neg();
    chk("rm_m_resp_ready_later", m_resp_ready, 0);
    cyc();
    idle_inputs();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
